// File: rtl/bitwise_logic_unit.sv
// Registered bitwise logic lane: eight ops on A/B or accumulator, results queued in an output FIFO.
// Optional LOGIC_UNIT_FLAGS_EN adds per-entry zero/parity flags (out_zero, out_parity).
module bitwise_logic_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_sel,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
`ifdef LOGIC_UNIT_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_parity
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
`ifdef LOGIC_UNIT_FLAGS_EN
  localparam int unsigned EntW = WIDTH + 2;
`else
  localparam int unsigned EntW = WIDTH;
`endif

  typedef enum logic [2:0] {
    OpNot  = 3'b000,
    OpAnd  = 3'b001,
    OpOr   = 3'b010,
    OpXor  = 3'b011,
    OpNand = 3'b100,
    OpNor  = 3'b101,
    OpXnor = 3'b110,
    OpPass = 3'b111
  } op_e;

  logic [EntW-1:0]  mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] opa, res;
  logic [EntW-1:0]  entry, head;
  logic             push, pop;

  always_comb begin
    in_ready  = (count_q != CntW'(DEPTH));
    out_valid = (count_q != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  always_comb begin
    opa = acc_sel ? acc_q : a;
    res = '0;
    case (op_e'(op))
      OpNot:   res = ~opa;
      OpAnd:   res = opa & b;
      OpOr:    res = opa | b;
      OpXor:   res = opa ^ b;
      OpNand:  res = ~(opa & b);
      OpNor:   res = ~(opa | b);
      OpXnor:  res = ~(opa ^ b);
      OpPass:  res = opa;
      default: res = opa;
    endcase
  end

`ifdef LOGIC_UNIT_FLAGS_EN
  always_comb entry = {^res, (res == '0), res};
`else
  always_comb entry = res;
`endif

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      acc_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= entry;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      // Clear wins over the push update; the push still used the old value.
      if (acc_clr)   acc_q <= '0;
      else if (push) acc_q <= res;
    end
  end

  always_comb begin
    head   = out_valid ? mem_q[rd_ptr_q] : '0;
    result = head[WIDTH-1:0];
`ifdef LOGIC_UNIT_FLAGS_EN
    out_zero   = head[WIDTH];
    out_parity = head[WIDTH+1];
`endif
  end

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Self-checking bench for bitwise_logic_unit (WIDTH=16, DEPTH=2) against a truth-table/queue model.
module tb_bitwise_logic_unit;

  localparam int W = 16;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, acc_sel, acc_clr, out_valid, out_ready;
  logic [2:0]   op;
  logic [W-1:0] a, b, result;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic         out_zero, out_parity;
`endif

  bitwise_logic_unit #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .acc_sel   (acc_sel),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
`ifdef LOGIC_UNIT_FLAGS_EN
    ,
    .out_zero  (out_zero),
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Model: per-op 4-entry truth table indexed by {a_bit, b_bit}, FIFO as a queue.
  logic [3:0]   tt [8];
  logic [W-1:0] mq [$];
  logic [W-1:0] macc;

  function automatic logic [W-1:0] ref_op(input logic [2:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    logic [W-1:0] r;
    logic [3:0]   t;
    t = tt[o];
    for (int i = 0; i < W; i++) r[i] = t[{x[i], y[i]}];
    return r;
  endfunction

  function automatic logic [W-1:0] exp_result();
    return (mq.size() > 0) ? mq[0] : '0;
  endfunction

  task automatic tick();
    bit           do_push, do_pop;
    logic [W-1:0] r;
    do_push = in_valid && (mq.size() < D);
    do_pop  = out_ready && (mq.size() > 0);
    r = ref_op(op, acc_sel ? macc : a, b);
    @(posedge clk);
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back(r);
    if (acc_clr) macc = '0;
    else if (do_push) macc = r;
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 2 * D && mq.size() > 0; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; acc_sel = 1'b0; acc_clr = 1'b0;
    op = 3'd0; a = '0; b = '0;
    mq.delete(); macc = '0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({in_ready, out_valid, result} !== {1'b1, 1'b0, 16'h0000})
      $display("FAIL reset_outputs got rdy=%b vld=%b res=%h want rdy=1 vld=0 res=0000",
               in_ready, out_valid, result);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_not();
    in_valid = 1'b1; out_ready = 1'b1; op = 3'b000; a = 16'h00FF; b = 16'h1234; acc_sel = 1'b0;
    tick();
    n_total++;
    if ({out_valid, result} !== {1'b1, 16'hFF00})
      $display("FAIL not_result got vld=%b res=%h want vld=1 res=ff00", out_valid, result);
    else n_pass++;
    drain();
  endtask

  task automatic test_acc_chain();
    out_ready = 1'b0; in_valid = 1'b1;
    op = 3'b011; a = 16'hF0F0; b = 16'h0FF0; acc_sel = 1'b0;
    tick();
    op = 3'b110; a = 16'hAAAA; b = 16'h0000; acc_sel = 1'b1;
    tick();
    in_valid = 1'b0; acc_sel = 1'b0;
    n_total++;
    if (result !== 16'hFF00) $display("FAIL chain_first got %h want ff00", result);
    else n_pass++;
    out_ready = 1'b1;
    tick();
    n_total++;
    if (result !== 16'h00FF) $display("FAIL chain_second got %h want 00ff", result);
    else n_pass++;
    drain();
  endtask

  task automatic test_full();
    out_ready = 1'b0; in_valid = 1'b1; op = 3'b111; acc_sel = 1'b0;
    a = 16'd1; tick();
    a = 16'd2; tick();
    a = 16'd3; tick();
    n_total++;
    if ({in_ready, out_valid, result} !== {1'b0, 1'b1, 16'd1})
      $display("FAIL full_hold got rdy=%b vld=%b res=%h want rdy=0 vld=1 res=0001",
               in_ready, out_valid, result);
    else n_pass++;
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    n_total++;
    if ({in_ready, result} !== {1'b1, 16'd2})
      $display("FAIL full_pop got rdy=%b res=%h want rdy=1 res=0002", in_ready, result);
    else n_pass++;
    in_valid = 1'b1; a = 16'd4;
    tick();
    n_total++;
    if ({in_ready, out_valid, result} !== {1'b1, 1'b1, 16'd4})
      $display("FAIL push_pop_same got rdy=%b vld=%b res=%h want rdy=1 vld=1 res=0004",
               in_ready, out_valid, result);
    else n_pass++;
    in_valid = 1'b0;
    tick();
    n_total++;
    if ({out_valid, result} !== {1'b0, 16'h0000})
      $display("FAIL empty_result got vld=%b res=%h want vld=0 res=0000", out_valid, result);
    else n_pass++;
  endtask

  task automatic test_acc_clr();
    out_ready = 1'b1; in_valid = 1'b1; op = 3'b111; acc_sel = 1'b0; a = 16'h1234;
    tick();
    acc_sel = 1'b1; acc_clr = 1'b1; a = 16'h5555;
    tick();
    n_total++;
    if (result !== 16'h1234) $display("FAIL clr_with_push got %h want 1234", result);
    else n_pass++;
    acc_clr = 1'b0;
    tick();
    n_total++;
    if ({out_valid, result} !== {1'b1, 16'h0000})
      $display("FAIL after_clr got vld=%b res=%h want vld=1 res=0000", out_valid, result);
    else n_pass++;
    acc_sel = 1'b0; a = 16'h00AB;
    tick();
    in_valid = 1'b0; out_ready = 1'b0; acc_clr = 1'b1;
    tick();
    n_total++;
    if ({out_valid, result} !== {1'b1, 16'h00AB})
      $display("FAIL clr_no_push got vld=%b res=%h want vld=1 res=00ab", out_valid, result);
    else n_pass++;
    acc_clr = 1'b0; in_valid = 1'b1; out_ready = 1'b1; acc_sel = 1'b1; a = 16'hFFFF;
    tick();
    n_total++;
    if ({out_valid, result} !== {1'b1, 16'h0000})
      $display("FAIL acc_cleared got vld=%b res=%h want vld=1 res=0000", out_valid, result);
    else n_pass++;
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; op = 3'b111; acc_sel = 1'b0; a = 16'hBEEF;
    tick();
    a = 16'hCAFE;
    tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    mq.delete(); macc = '0;
    n_total++;
    if ({in_ready, out_valid, result} !== {1'b1, 1'b0, 16'h0000})
      $display("FAIL async_reset got rdy=%b vld=%b res=%h want rdy=1 vld=0 res=0000",
               in_ready, out_valid, result);
    else n_pass++;
    #1 rst = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; acc_sel = 1'b1; a = 16'h7777;
    tick();
    n_total++;
    if ({out_valid, result} !== {1'b1, 16'h0000})
      $display("FAIL acc_after_reset got vld=%b res=%h want vld=1 res=0000", out_valid, result);
    else n_pass++;
    drain();
  endtask

`ifdef LOGIC_UNIT_FLAGS_EN
  task automatic test_flags();
    n_total++;
    if ({out_zero, out_parity} !== 2'b00)
      $display("FAIL flags_empty got z=%b p=%b want z=0 p=0", out_zero, out_parity);
    else n_pass++;
    in_valid = 1'b1; out_ready = 1'b1; op = 3'b001; acc_sel = 1'b0;
    a = 16'h00FF; b = 16'hFF00;
    tick();
    n_total++;
    if ({result, out_zero, out_parity} !== {16'h0000, 1'b1, 1'b0})
      $display("FAIL flags_and got res=%h z=%b p=%b want res=0000 z=1 p=0",
               result, out_zero, out_parity);
    else n_pass++;
    drain();
  endtask
`endif

  task automatic test_random();
    logic [W-1:0] er;
    for (int i = 0; i < 400; i++) begin
      er = exp_result();
      n_total++;
      if ({in_ready, out_valid, result} !== {mq.size() < D, mq.size() > 0, er})
        $display("FAIL random_%0d got rdy=%b vld=%b res=%h want rdy=%b vld=%b res=%h", i,
                 in_ready, out_valid, result, mq.size() < D, mq.size() > 0, er);
      else n_pass++;
`ifdef LOGIC_UNIT_FLAGS_EN
      n_total++;
      if ({out_zero, out_parity} !==
          {(mq.size() > 0) && (er == '0), ($countones(er) % 2) == 1})
        $display("FAIL random_flags_%0d got z=%b p=%b res=%h", i, out_zero, out_parity, er);
      else n_pass++;
`endif
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      op        = 3'($urandom_range(0, 7));
      a         = W'($urandom);
      b         = W'($urandom);
      acc_sel   = $urandom_range(0, 1) == 1;
      acc_clr   = ($urandom_range(0, 9) == 0);
      tick();
    end
    drain();
  endtask

  initial begin
    tt[0] = 4'b0011;  // NOT A
    tt[1] = 4'b1000;  // AND
    tt[2] = 4'b1110;  // OR
    tt[3] = 4'b0110;  // XOR
    tt[4] = 4'b0111;  // NAND
    tt[5] = 4'b0001;  // NOR
    tt[6] = 4'b1001;  // XNOR
    tt[7] = 4'b1100;  // PASS A
    test_reset();
    test_not();
    test_acc_chain();
    test_full();
    test_acc_clr();
    test_reset_mid();
`ifdef LOGIC_UNIT_FLAGS_EN
    test_flags();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
